cp0_regfile: RTL
================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file. Consumes the exception-commit bundle from the exception detector: cp0_exp_en, cp0_exl_clean, code, epc, bad_vaddr, bd.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC, and serves mfc0/mtc0.
- Returns epc_address, allow_interrupt and interrupt_flag to the exception detector, closing the loop.
- Sits at the writeback/commit boundary of the pipeline.

Parameters:
- STATUS_RESET, 32'h0040_0000, Status reset value (BEV=1, IM=0, EXL=0, IE=0).
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (power of 2, ≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- hw_int  in  6  hardware interrupt lines, level-sensitive, sampled every cycle.
- mtc0_wen  in  1  write enable for a CP0 register write.
- mtc0_addr  in  5  register number (rd); sel is always 0.
- mtc0_wdata  in  32  write data.
- mfc0_addr  in  5  read register number.
- mfc0_rdata  out  32  combinational read of current registered state, no write bypass.
- cp0_exp_en  in  1  exception commit.
- cp0_exl_clean  in  1  eret commit.
- cp0_exp_epc  in  32  EPC candidate.
- cp0_exp_code  in  5  ExcCode.
- cp0_exp_bd  in  1  branch-delay flag.
- cp0_exp_bad_vaddr  in  32  faulting address.
- cp0_exp_bad_vaddr_wen  in  1  BadVAddr write enable.
- epc_address  out  32  current EPC.
- allow_interrupt  out  1  Status.IE & ~Status.EXL.
- interrupt_flag  out  8  Cause.IP[7:0] & Status.IM[7:0].

Behaviour:
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Unmapped addresses read 0; writes to them are ignored.
- Reset values: BadVAddr=0, Count=0, Compare=0, Status=STATUS_RESET, Cause=0, EPC=0. All outputs follow from these: epc_address=0, allow_interrupt=0, interrupt_flag=0, mfc0_rdata per map. Count prescaler cleared.
- Status:
  - Writable bits via mtc0: IM[15:8], EXL[1], IE[0].
  - All other bits hold reset value; BEV is read-only 1.
- Cause:
  - BD[31] and ExcCode[6:2] are written only by exceptions.
  - TI[30] is set by timer match.
  - IP[7:2] is registered every cycle: IP[7] = hw_int[5] | TI; IP[6:2] = hw_int[4:0].
  - IP[1:0] is software-writable via mtc0.
  - All other bits read 0.
- Exception (cp0_exp_en=1):
  - Status.EXL←1; Cause.ExcCode←cp0_exp_code.
  - If Status.EXL was 0: EPC←cp0_exp_epc and Cause.BD←cp0_exp_bd. If EXL was already 1, EPC and BD are held.
  - BadVAddr←cp0_exp_bad_vaddr iff cp0_exp_bad_vaddr_wen.
- Eret (cp0_exl_clean=1): Status.EXL←0. No other register changes.
- Priority:
  - cp0_exp_en and cp0_exl_clean are mutually exclusive. If both are asserted, the exception wins.
  - Any mtc0 in the same cycle as exp_en or exl_clean is discarded, because the instruction is squashed.
- Count:
  - A prescaler counts cycles; Count increments when the prescaler wraps, modulo 2^32 (0xFFFF_FFFF→0).
  - An mtc0 to Count loads the value and clears the prescaler.
- Compare:
  - An mtc0 to Compare loads the value and clears TI in the same edge.
  - TI sets on the edge where the Count next value equals Compare and Count actually changes. The match check covers both increments and mtc0 loads of Count.
  - If a Compare write and a match occur in the same cycle, the write wins (TI=0).
- Latency:
  - mtc0 is visible on mfc0_rdata and the derived outputs one cycle after the write edge.
  - hw_int reaches interrupt_flag after 1 cycle.
- Reset mid-operation: all state returns to reset values on the same edge; pending TI is lost.

Optional Feature:
- CP0_TIMER_EN defined: Count, Compare and TI are implemented as described above.
- CP0_TIMER_EN undefined:
  - Count, Compare and TI are removed.
  - Addresses 9 and 11 read 0 and ignore writes.
  - IP[7] = hw_int[5] only.

Decomposition:
- Package cp0_pkg holds:
  - Register number localparams: CP0_BADVADDR, CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC.
  - Packed struct typedefs for Status and Cause field layout.
  - ExcCode enum: INT=0x00, ADEL=0x04, ADES=0x05, SYS=0x08, BP=0x09, RI=0x0a, OV=0x0c.
- One sub-module, cp0_timer: prescaler, Count, Compare, TI set/clear. It is instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset then idle → mfc0 addr 12 reads 0x0040_0000; allow_interrupt=0; interrupt_flag=0; epc_address=0.
- mtc0 Status=0x0000_FF01, then hw_int=6'b000100 → next cycle allow_interrupt=1; interrupt_flag=0x10 one cycle after hw_int rises.
- cp0_exp_en with code 0x04, epc 0xBFC0_0100, bd=1, bad_vaddr 0x1234_5671 with wen=1 → EPC=0xBFC0_0100; Cause=0x8000_0010; BadVAddr=0x1234_5671; EXL=1; allow_interrupt=0.
- Nested exception while EXL=1, with epc 0x8000_0000 and code 0x0c → EPC stays 0xBFC0_0100; ExcCode=0x0c. Then cp0_exl_clean → EXL=0, EPC unchanged.
- CP0_TIMER_EN: mtc0 Count=10, Compare=12 (COUNT_DIV=2) → TI=1 and Cause bit 15 set after ~4 cycles. mtc0 Compare=100 → TI=0 next cycle. Count=0xFFFF_FFFF wraps to 0.
- mtc0 Cause=0x0000_0300 in the same cycle as cp0_exp_en → Cause.IP[1:0] stays 0 and only the exception update lands. Same write alone → IP[1:0]=2'b11.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, Status/Cause field layouts and ExcCode values
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef struct packed {
    logic [15:0] hi;
    logic [7:0]  im;
    logic [5:0]  mid;
    logic        exl;
    logic        ie;
  } status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsvd_hi;
    logic [7:0]  ip;
    logic        rsvd_mid;
    logic [4:0]  exc_code;
    logic [1:0]  rsvd_lo;
  } cause_t;

  typedef enum logic [4:0] {
    INT  = 5'h00,
    ADEL = 5'h04,
    ADES = 5'h05,
    SYS  = 5'h08,
    BP   = 5'h09,
    RI   = 5'h0a,
    OV   = 5'h0c
  } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count prescaler, Count/Compare registers and timer interrupt (TI)
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        count_wen_i,
  input  logic        compare_wen_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick;

  assign tick = (COUNT_DIV <= 1) ? 1'b1 : (presc_q == PW'(COUNT_DIV - 1));

  always_comb begin
    presc_d   = (count_wen_i || tick) ? '0 : presc_q + 1'b1;
    count_d   = count_wen_i ? wdata_i : (tick ? count_q + 32'd1 : count_q);
    compare_d = compare_wen_i ? wdata_i : compare_q;
    ti_d      = ti_q;
    // A Compare write in the same cycle as a match still leaves TI clear.
    if (compare_wen_i)
      ti_d = 1'b0;
    else if (count_d != count_q && count_d == compare_q)
      ti_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file with exception/eret commit; timer enabled by CP0_TIMER_EN
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
  parameter int unsigned COUNT_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_wen,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_rdata,
  input  logic        cp0_exp_en,
  input  logic        cp0_exl_clean,
  input  logic [31:0] cp0_exp_epc,
  input  logic [4:0]  cp0_exp_code,
  input  logic        cp0_exp_bd,
  input  logic [31:0] cp0_exp_bad_vaddr,
  input  logic        cp0_exp_bad_vaddr_wen,
  output logic [31:0] epc_address,
  output logic        allow_interrupt,
  output logic [7:0]  interrupt_flag
);

  status_t     status_q, status_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [7:0]  ip_q, ip_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        ti;
  logic        mtc0_ok;
  cause_t      cause;

  // A commit squashes the mtc0 issued alongside it.
  assign mtc0_ok = mtc0_wen & ~cp0_exp_en & ~cp0_exl_clean;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk_i         (clk),
    .rst_i         (rst),
    .count_wen_i   (mtc0_ok && mtc0_addr == CP0_COUNT),
    .compare_wen_i (mtc0_ok && mtc0_addr == CP0_COMPARE),
    .wdata_i       (mtc0_wdata),
    .count_o       (count),
    .compare_o     (compare),
    .ti_o          (ti)
  );
`else
  logic div_unused;
  assign div_unused = ^COUNT_DIV;
  assign ti = 1'b0;
`endif

  always_comb begin
    status_d   = status_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ip_d       = {hw_int[5] | ti, hw_int[4:0], ip_q[1:0]};
    if (cp0_exp_en) begin
      status_d.exl = 1'b1;
      exc_code_d   = cp0_exp_code;
      if (!status_q.exl) begin
        epc_d = cp0_exp_epc;
        bd_d  = cp0_exp_bd;
      end
      if (cp0_exp_bad_vaddr_wen)
        badvaddr_d = cp0_exp_bad_vaddr;
    end else if (cp0_exl_clean) begin
      status_d.exl = 1'b0;
    end else if (mtc0_ok) begin
      case (mtc0_addr)
        CP0_STATUS: begin
          status_d.im  = mtc0_wdata[15:8];
          status_d.exl = mtc0_wdata[1];
          status_d.ie  = mtc0_wdata[0];
        end
        CP0_CAUSE: ip_d[1:0] = mtc0_wdata[9:8];
        CP0_EPC:   epc_d     = mtc0_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= status_t'(STATUS_RESET);
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_q       <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      status_q   <= status_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_q       <= ip_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    cause          = '0;
    cause.bd       = bd_q;
    cause.ti       = ti;
    cause.ip       = ip_q;
    cause.exc_code = exc_code_q;
  end

  always_comb begin
    case (mfc0_addr)
      CP0_BADVADDR: mfc0_rdata = badvaddr_q;
`ifdef CP0_TIMER_EN
      CP0_COUNT:    mfc0_rdata = count;
      CP0_COMPARE:  mfc0_rdata = compare;
`endif
      CP0_STATUS:   mfc0_rdata = status_q;
      CP0_CAUSE:    mfc0_rdata = cause;
      CP0_EPC:      mfc0_rdata = epc_q;
      default:      mfc0_rdata = '0;
    endcase
  end

  assign epc_address     = epc_q;
  assign allow_interrupt = status_q.ie & ~status_q.exl;
  assign interrupt_flag  = ip_q & status_q.im;

endmodule
